// File: rtl/rip_ro_counter_bank.sv
// Bank of gated ring oscillators with per-channel rising-edge counters.
// A start runs the enabled rings for a gate window, then streams {channel, count} results.

module rip_ro_channel #(
    parameter int RO_SIZE        = 5,
    parameter int INVERTER_DELAY = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic             clear,
    input  logic             count_en,
    output logic             ro_raw,
    output logic [CNT_W-1:0] count
);
    (* keep = "true", dont_touch = "true", allow_combinatorial_loops = "true" *)
    logic ring [0:RO_SIZE];

    // Stage 0 is gated: with run low the odd-length chain parks at a static level.
    assign ring[0] = run & ring[RO_SIZE];
    for (genvar k = 0; k < RO_SIZE; k++) begin : g_inv
        assign #(INVERTER_DELAY) ring[k+1] = ~ring[k];
    end

    logic [2:0]       smp_q, smp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;

    // smp[0..1] synchronise the ring tap, smp[2] is the previous synchronised sample.
    assign rise   = smp_q[1] & ~smp_q[2];
    assign ro_raw = smp_q[1];
    assign count  = cnt_q;

    always_comb begin
        smp_d = {smp_q[1:0], ring[1]};
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && rise && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            smp_q <= '0;
            cnt_q <= '0;
        end else begin
            smp_q <= smp_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

module rip_ro_counter_bank #(
    parameter int NUM_RO         = 4,
    parameter int RO_SIZE        = 5,
    parameter int INVERTER_DELAY = 1,
    parameter int CNT_W          = 16,
    parameter int GATE_W         = 16,
    parameter int SETTLE_CYCLES  = 4,
    localparam int CH_W          = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [NUM_RO-1:0] ch_en,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CH_W-1:0]   res_ch,
    output logic [CNT_W-1:0]  res_count,
    output logic [NUM_RO-1:0] ro_raw
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DRAIN} state_e;
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

    state_e                   state_q, state_d;
    logic [ST_W-1:0]          settle_q, settle_d;
    logic [GATE_W-1:0]        gate_q, gate_d;
    logic [NUM_RO-1:0]        ch_en_q, ch_en_d;
    logic [NUM_RO-1:0]        pend_q, pend_d;
    logic [CH_W-1:0]          res_ch_q, res_ch_d;
    logic [CNT_W-1:0]         res_count_q, res_count_d;
    logic [NUM_RO-1:0][CNT_W-1:0] cnt;
    logic [NUM_RO-1:0]        run;
    logic                     rings_on, measuring, clear;
    logic [CH_W-1:0]          sel;

    assign rings_on  = (state_q == S_SETTLE) || (state_q == S_MEASURE);
    assign measuring = (state_q == S_MEASURE);
    assign busy      = (state_q != S_IDLE);

    for (genvar i = 0; i < NUM_RO; i++) begin : g_ch
        assign run[i] = rstn & rings_on & ch_en_q[i];
        rip_ro_channel #(
            .RO_SIZE        (RO_SIZE),
            .INVERTER_DELAY (INVERTER_DELAY),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rstn     (rstn),
            .run      (run[i]),
            .clear    (clear),
            .count_en (measuring & ch_en_q[i]),
            .ro_raw   (ro_raw[i]),
            .count    (cnt[i])
        );
    end

    // Lowest pending channel is the one presented in DRAIN.
    always_comb begin
        sel = '0;
        for (int i = NUM_RO - 1; i >= 0; i--) begin
            if (pend_q[i]) sel = CH_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        gate_d      = gate_q;
        ch_en_d     = ch_en_q;
        pend_d      = pend_q;
        res_ch_d    = res_ch_q;
        res_count_d = res_count_q;
        clear       = 1'b0;
        done        = 1'b0;
        res_valid   = 1'b0;
        res_ch      = res_ch_q;
        res_count   = res_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                    gate_d   = gate_cycles;
                    ch_en_d  = ch_en;
                    pend_d   = ch_en;
                    clear    = 1'b1;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q + 1'b1;
                if (settle_q == ST_W'(SETTLE_CYCLES - 1)) begin
                    state_d = (gate_q == '0) ? S_DRAIN : S_MEASURE;
                end
            end
            S_MEASURE: begin
                gate_d = gate_q - 1'b1;
                if (gate_q == GATE_W'(1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (|pend_q) begin
                    res_valid   = 1'b1;
                    res_ch      = sel;
                    res_count   = cnt[sel];
                    res_ch_d    = sel;
                    res_count_d = cnt[sel];
                    if (res_ready) pend_d[sel] = 1'b0;
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pend_d  = '0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            settle_q    <= '0;
            gate_q      <= '0;
            ch_en_q     <= '0;
            pend_q      <= '0;
            res_ch_q    <= '0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            gate_q      <= gate_d;
            ch_en_q     <= ch_en_d;
            pend_q      <= pend_d;
            res_ch_q    <= res_ch_d;
            res_count_q <= res_count_d;
        end
    end
endmodule

// File: tb/tb_rip_ro_counter_bank.sv
// Bench for rip_ro_counter_bank: phase/queue model checked every cycle, plus literal per-run checks.
// Ring period 50, clk period 10: each enabled channel sees gate/5 rising edges (+-1).

module tb_rip_ro_counter_bank;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0, abort = 1'b0, res_ready = 1'b0;
    logic [15:0] gate_cycles = '0;
    logic [3:0]  ch_en = '0;

    logic        busy, done, res_valid;
    logic [1:0]  res_ch;
    logic [15:0] res_count;
    logic [3:0]  ro_raw;
    logic        busy_s, done_s, res_valid_s;
    logic [1:0]  res_ch_s;
    logic [3:0]  res_count_s;
    logic [3:0]  ro_raw_s;

    rip_ro_counter_bank #(.NUM_RO(4), .RO_SIZE(5), .INVERTER_DELAY(5), .CNT_W(16),
                          .GATE_W(16), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .gate_cycles(gate_cycles),
        .ch_en(ch_en), .busy(busy), .done(done), .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_count(res_count), .ro_raw(ro_raw));

    // Narrow-counter copy sharing all inputs, to exercise saturation.
    rip_ro_counter_bank #(.NUM_RO(4), .RO_SIZE(5), .INVERTER_DELAY(5), .CNT_W(4),
                          .GATE_W(16), .SETTLE_CYCLES(4)) dut_sat (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .gate_cycles(gate_cycles),
        .ch_en(ch_en), .busy(busy_s), .done(done_s), .res_valid(res_valid_s), .res_ready(res_ready),
        .res_ch(res_ch_s), .res_count(res_count_s), .ro_raw(ro_raw_s));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_rng(input string nm, input longint act, input longint lo, input longint hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Model: phase 0 idle, 1 settle, 2 measure, 3 drain; queue of channels still to report.
    int         m_phase = 0, m_left = 0, m_gate = 0, m_last_ch = 0;
    int         m_q[$];
    logic [3:0] m_en = '0, m_snap = '0;
    logic       p_stall = 1'b0;
    int         p_ch = 0, p_cnt = 0;
    int         log_ch[$], log_cnt[$], log_scnt[$];
    int         n_done = 0, n_busy = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            check("rst_busy", busy, 0);
            check("rst_valid", res_valid, 0);
            check("rst_done", done, 0);
            check("rst_ch", res_ch, 0);
            check("rst_cnt", res_count, 0);
            check("rst_raw", ro_raw, 0);
            m_phase = 0; m_q.delete(); m_last_ch = 0; p_stall = 1'b0;
        end else begin
            automatic bit e_valid = (m_phase == 3) && (m_q.size() > 0);
            automatic bit e_done  = (m_phase == 3) && (m_q.size() == 0) && !abort;
            automatic int lo = (m_gate == 0) ? 0 : m_gate / 5 - 1;
            automatic int hi = (m_gate == 0) ? 0 : m_gate / 5 + 1;
            check("busy", busy, m_phase != 0);
            check("valid", res_valid, e_valid);
            check("done", done, e_done);
            check("s_valid", res_valid_s, e_valid);
            if (e_valid) begin
                check("res_ch", res_ch, m_q[0]);
                check("s_res_ch", res_ch_s, m_q[0]);
                check_rng("res_count", res_count, lo, hi);
                check_rng("s_res_count", res_count_s, (lo > 15) ? 15 : lo, (hi > 15) ? 15 : hi);
                m_last_ch = m_q[0];
            end else begin
                check("hold_ch", res_ch, m_last_ch);
            end
            if (p_stall) begin
                check("stall_ch", res_ch, p_ch);
                check("stall_cnt", res_count, p_cnt);
            end
            p_stall = res_valid && !res_ready;
            p_ch = res_ch; p_cnt = res_count;
            if (m_phase != 0)
                for (int i = 0; i < 4; i++)
                    if (!m_en[i]) check($sformatf("held_raw%0d", i), ro_raw[i], m_snap[i]);

            if (busy) n_busy++;
            if (done) n_done++;
            if (res_valid && res_ready) begin
                log_ch.push_back(res_ch); log_cnt.push_back(res_count); log_scnt.push_back(res_count_s);
            end

            if (m_phase != 0 && abort) begin
                m_phase = 0; m_q.delete();
            end else begin
                case (m_phase)
                    0: if (start) begin
                        m_phase = 1; m_left = 4; m_gate = gate_cycles; m_en = ch_en; m_snap = ro_raw;
                        m_q.delete();
                        for (int i = 0; i < 4; i++) if (ch_en[i]) m_q.push_back(i);
                    end
                    1: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = (m_gate == 0) ? 3 : 2;
                            m_left = m_gate;
                        end
                    end
                    2: begin
                        m_left--;
                        if (m_left == 0) m_phase = 3;
                    end
                    default: begin
                        if (m_q.size() == 0) m_phase = 0;
                        else if (res_ready) void'(m_q.pop_front());
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start(input logic [3:0] en, input int g, input logic rdy, input logic ab);
        tick();
        log_ch.delete(); log_cnt.delete(); log_scnt.delete();
        n_done = 0; n_busy = 0;
        ch_en = en; gate_cycles = g[15:0]; res_ready = rdy; start = 1'b1; abort = ab;
        tick();
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int c = 0;
        while (busy && c < 3000) begin tick(); c++; end
        check({nm, "_idle_timeout"}, busy, 0);
    endtask

    task automatic wait_valid(input string nm);
        int c = 0;
        while (!res_valid && c < 3000) begin tick(); c++; end
        check({nm, "_valid_timeout"}, res_valid, 1);
    endtask

    task automatic expect_run(input string nm, input int n, input int ech[4], input int lo, input int hi,
                              input int slo, input int shi, input int busy_cyc);
        check({nm, "_nres"}, log_ch.size(), n);
        check({nm, "_ndone"}, n_done, 1);
        if (busy_cyc >= 0) check({nm, "_busy_cycles"}, n_busy, busy_cyc);
        for (int i = 0; i < n && i < log_ch.size(); i++) begin
            check($sformatf("%s_ch%0d", nm, i), log_ch[i], ech[i]);
            check_rng($sformatf("%s_cnt%0d", nm, i), log_cnt[i], lo, hi);
            check_rng($sformatf("%s_scnt%0d", nm, i), log_scnt[i], slo, shi);
        end
    endtask

    initial begin
        #1 rstn = 1'b0;
        repeat (3) tick();
        check("lit_rst_busy", busy, 0);
        check("lit_rst_valid", res_valid, 0);
        rstn = 1'b1;
        repeat (4) tick();

        // All channels, long window, consumer always ready.
        run_start(4'b1111, 1000, 1'b1, 1'b0);
        wait_idle("A");
        expect_run("A", 4, '{0, 1, 2, 3}, 199, 201, 15, 15, 1009);
        repeat (5) tick();

        // Sparse enable; a start while busy must be ignored.
        run_start(4'b1010, 500, 1'b1, 1'b0);
        repeat (100) tick();
        ch_en = 4'b0101; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("B");
        expect_run("B", 2, '{1, 3, 0, 0}, 99, 101, 15, 15, 507);
        repeat (5) tick();

        // Back-pressure: stall 20 cycles, then toggle ready.
        run_start(4'b1111, 100, 1'b0, 1'b0);
        wait_valid("C");
        repeat (20) tick();
        check("C_stall_valid", res_valid, 1);
        check("C_stall_ch", res_ch, 0);
        for (int c = 0; c < 100 && busy; c++) begin
            res_ready = ~res_ready;
            tick();
        end
        check("C_idle", busy, 0);
        expect_run("C", 4, '{0, 1, 2, 3}, 19, 21, 15, 15, -1);
        repeat (5) tick();

        // Abort at measure cycle 300.
        run_start(4'b1111, 1000, 1'b1, 1'b0);
        repeat (304) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        check("abort_ndone", n_done, 0);
        check("abort_nres", log_ch.size(), 0);
        repeat (5) tick();

        // Reset while stalled in DRAIN.
        run_start(4'b1111, 200, 1'b0, 1'b0);
        wait_valid("R");
        tick();
        rstn = 1'b0;
        #1;
        check("rst_drain_busy", busy, 0);
        check("rst_drain_valid", res_valid, 0);
        check("rst_drain_cnt", res_count, 0);
        check("rst_drain_ndone", n_done, 0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (4) tick();

        run_start(4'b1111, 200, 1'b1, 1'b0);
        wait_idle("D");
        expect_run("D", 4, '{0, 1, 2, 3}, 39, 41, 15, 15, 209);
        repeat (5) tick();

        // No channels enabled, start together with abort in IDLE.
        run_start(4'b0000, 50, 1'b1, 1'b1);
        wait_idle("E");
        expect_run("E", 0, '{0, 0, 0, 0}, 0, 0, 0, 0, 55);
        repeat (5) tick();

        // Zero-length gate window.
        run_start(4'b0001, 0, 1'b1, 1'b0);
        wait_idle("F");
        expect_run("F", 1, '{0, 0, 0, 0}, 0, 0, 0, 0, 6);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rip_ro_counter_bank.md
Name: rip_ro_counter_bank

Overview:
Parametrised bank of NUM_RO gated ring oscillators, each with a frequency counter, for reservoir entropy and process characterisation. A start command runs all enabled oscillators for a programmable gate window of clk cycles. The block counts synchronised rising edges per channel. It then streams one {channel, count} result per enabled channel over a valid/ready interface.

Parameters:
NUM_RO, 4, number of oscillator channels (>=1)
RO_SIZE, 5, inverters per ring (odd, >=3)
INVERTER_DELAY, 1, per-inverter simulation delay (time units)
CNT_W, 16, edge-counter width per channel
GATE_W, 16, width of gate_cycles
SETTLE_CYCLES, 4, clk cycles between oscillator enable and counting (>=2)
CH_W, derived, max(1, $clog2(NUM_RO))

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  begin measurement; accepted only in IDLE
abort  in  1  return to IDLE next cycle from any non-IDLE state
gate_cycles  in  GATE_W  measurement window length; latched on start
ch_en  in  NUM_RO  per-channel enable; latched on start
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse on normal completion
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_ch  out  CH_W  channel index of current result
res_count  out  CNT_W  edge count of current result
ro_raw  out  NUM_RO  synchronised oscillator levels (debug/entropy tap)

Behaviour:
- Reset (rstn low, async): state=IDLE; busy, done, res_valid, res_ch, res_count, ro_raw = 0; counters and latched config = 0; all rings held.
- Ring i runs only when rstn=1, state is SETTLE or MEASURE, and ch_en_q[i]=1. Otherwise stage-0 input is forced 0, so the ring parks at a static level. Free-running period = 2*RO_SIZE*INVERTER_DELAY. Rings carry keep/dont-touch/allow-combinatorial-loop attributes.
- Each ring output passes a 2-flop synchroniser into ro_raw, then a rising-edge detector (previous-sample register).
- Counting is valid only when the ring period > 2 clk periods. Faster rings alias; this is documented, not detected.
- FSM states:
  - IDLE: on start, latch gate_cycles and ch_en, clear all counters, go to SETTLE.
  - SETTLE: run SETTLE_CYCLES cycles so synchronisers and edge detectors prime; no counting; go to MEASURE.
  - MEASURE: gate counter loads gate_cycles and decrements each cycle. An enabled channel's counter increments on each detected rising edge and saturates at 2^CNT_W-1. MEASURE lasts exactly gate_cycles cycles. gate_cycles=0 skips MEASURE (all counts 0). Then go to DRAIN.
  - DRAIN: walk channels in ascending index order and skip disabled ones. res_valid is asserted with res_ch/res_count stable until res_valid&&res_ready. The next enabled channel is presented the cycle after the handshake (back-to-back allowed). After the last transfer: done=1 for one cycle, go to IDLE.
- No enabled channels: DRAIN emits nothing; done pulses on the first DRAIN cycle.
- start is ignored while busy. start with abort in IDLE: start wins.
- abort in SETTLE/MEASURE/DRAIN: next cycle state=IDLE, res_valid=0, no done, rings held, counts discarded.
- busy rises the cycle after start is accepted and falls the cycle after done or abort.
- res_ch and res_count hold their last values in IDLE. res_valid is 0 outside DRAIN.

Test Plan:
- INVERTER_DELAY=5, RO_SIZE=5 (period 50 ns), clk 10 ns, ch_en=4'b1111, gate_cycles=1000, res_ready=1 -> four results ch 0,1,2,3, each res_count 200±1; done pulses once; busy high SETTLE_CYCLES+1000+drain cycles.
- ch_en=4'b1010, gate_cycles=500 -> exactly two results, ch 1 then 3, each ~100; channels 0/2 ro_raw constant throughout.
- res_ready held low 20 cycles in DRAIN -> res_valid stays high, res_ch=0 and res_count unchanged; then toggling res_ready drains in order with no loss or duplication.
- CNT_W=4, gate_cycles=1000 -> every res_count = 15 (saturation, no wrap).
- abort mid-MEASURE (cycle 300), then rstn low during DRAIN of a second run -> each case: IDLE next cycle/immediately, no done, res_valid=0; the following start/gate_cycles=200 yields counts ~40.
- ch_en=0 or gate_cycles=0 -> ch_en=0: no results, done pulses; gate_cycles=0 with ch_en=4'b0001: one result ch 0, count 0.
